// File: rtl/ls_issue_if.sv
// ls_issue_if: request, load-response and memory-port bundle of the load/store issue unit.
//  master: requester/consumer/memory side (drives req_*, resp_ready, mem_rdata)
//  slave : the issue unit (drives req_ready, resp_*, mem_rd, mem_addr, mem_wr_data)
interface ls_issue_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] resp_addr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rdata;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_addr, mem_rd, mem_addr, mem_wr_data
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_addr, mem_rd, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/ls_issue_unit.sv
// ls_issue_unit: FIFO-buffered load/store issue stage in front of a word-addressed memory.
//  clk, rst_n (sync, active low); bus: request, load response and memory port (slave side);
//  busy: FIFO non-empty or FSM active; ld_count/st_count: issued op counters (wrap at 256).
module ls_issue_unit #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  ls_issue_if.slave  bus,
  output logic       busy,
  output logic [7:0] ld_count,
  output logic [7:0] st_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MEM_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;
  op_t           fifo_q [DEPTH];
  op_t           head;
  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          mem_rd_q, mem_rd_d, resp_valid_q, resp_valid_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d, resp_addr_q, resp_addr_d;
  logic [DW-1:0] mem_wr_data_q, mem_wr_data_d, resp_data_q, resp_data_d;
  logic [7:0]    ld_count_q, ld_count_d, st_count_q, st_count_d;
  logic          push, pop, empty, full;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (PW+1)'(DEPTH);
  assign push  = bus.req_valid && !full;
  assign head  = fifo_q[rd_ptr_q];
  // The op presented in ISSUE is a store exactly when mem_rd is low, so mem_rd_q doubles as the op type.
  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    pop           = 1'b0;
    mem_rd_d      = 1'b1;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    resp_valid_d  = resp_valid_q;
    resp_data_d   = resp_data_q;
    resp_addr_d   = resp_addr_q;
    ld_count_d    = ld_count_q;
    st_count_d    = st_count_q;
    case (state_q)
      IDLE: pop = !empty;
      ISSUE: begin
        st_count_d = st_count_q + {7'd0, !mem_rd_q};
        ld_count_d = ld_count_q + {7'd0, mem_rd_q};
        wcnt_d     = '0;
        pop        = !mem_rd_q && !empty;
        state_d    = mem_rd_q ? WAIT : IDLE;
      end
      WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == CW'(MEM_LAT - 1)) begin
          resp_valid_d = 1'b1;
          resp_data_d  = bus.mem_rdata;
          resp_addr_d  = mem_addr_q;
          state_d      = RESP;
        end
      end
      RESP: if (bus.resp_ready) begin
        resp_valid_d = 1'b0;
        pop          = !empty;
        state_d      = IDLE;
      end
    endcase
    // Write data is only loaded for stores so it holds its last value across loads.
    if (pop) begin
      state_d       = ISSUE;
      mem_rd_d      = !head.we;
      mem_addr_d    = head.addr;
      mem_wr_data_d = head.we ? head.wdata : mem_wr_data_q;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      mem_rd_q      <= 1'b1;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_addr_q   <= '0;
      ld_count_q    <= '0;
      st_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_addr_q   <= resp_addr_d;
      ld_count_q    <= ld_count_d;
      st_count_q    <= st_count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {bus.req_we, bus.req_addr, bus.req_wdata};
  end
  assign bus.req_ready   = !full;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_addr   = resp_addr_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign busy            = !empty || state_q != IDLE;
  assign ld_count        = ld_count_q;
  assign st_count        = st_count_q;
endmodule
